// File: rtl/queue_sched_pkg.sv
// Shared widths, event record and sequencer state encoding for the queue scheduler.
package queue_sched_pkg;

    localparam int unsigned OP_W    = 10;
    localparam int unsigned INSTR_W = 8;
    localparam int unsigned DLY_W   = 16;

    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [INSTR_W-1:0] instr;
        logic [DLY_W-1:0]   delay;
    } sched_event_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

endpackage

// File: rtl/sched_fifo.sv
// Synchronous FIFO of timed events; head entry is visible combinationally on rdata.
module sched_fifo
    import queue_sched_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter type         entry_t = sched_event_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  entry_t                 wdata,
    output entry_t                 rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Pointers are exactly AW bits wide, so DEPTH being a power of two makes the wrap free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/queue_scheduler.sv
// Timed sequencer: buffers {op, instr, delay} events and releases each as a
// one-cycle strobe exactly delay+1 running edges after it leaves the buffer.
module queue_scheduler
    import queue_sched_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned OP_W    = queue_sched_pkg::OP_W,
    parameter int unsigned INSTR_W = queue_sched_pkg::INSTR_W,
    parameter int unsigned DLY_W   = queue_sched_pkg::DLY_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        in_op,
    input  logic [INSTR_W-1:0]     in_instr,
    input  logic [DLY_W-1:0]       in_delay,
    output logic                   out_stb,
    output logic [OP_W-1:0]        out_op,
    output logic [INSTR_W-1:0]     out_instr,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy
);

    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [INSTR_W-1:0] instr;
        logic [DLY_W-1:0]   delay;
    } evt_t;

    state_t             state_q, state_d;
    logic [DLY_W-1:0]   cnt_q, cnt_d;
    logic [OP_W-1:0]    lat_op_q, lat_op_d;
    logic [INSTR_W-1:0] lat_instr_q, lat_instr_d;
    logic               out_stb_q, out_stb_d;
    logic [OP_W-1:0]    out_op_q, out_op_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;

    logic full, empty, push, pop;
    evt_t wdata, head;

    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready && !flush;
    assign wdata    = '{op: in_op, instr: in_instr, delay: in_delay};

    sched_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (evt_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wdata),
        .rdata (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run && !empty) begin
                        pop     = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (run && cnt_q == '0) state_d = ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (run && !empty) begin
                        pop     = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A flushed event never reaches ISSUE, so the strobe condition below already excludes it.
    always_comb begin
        cnt_d       = cnt_q;
        lat_op_d    = lat_op_q;
        lat_instr_d = lat_instr_q;
        out_stb_d   = 1'b0;
        out_op_d    = out_op_q;
        out_instr_d = out_instr_q;
        if (flush) begin
            cnt_d = '0;
        end else if (pop) begin
            cnt_d       = head.delay;
            lat_op_d    = head.op;
            lat_instr_d = head.instr;
        end else if (state_q == ST_WAIT && run && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (state_q == ST_WAIT && state_d == ST_ISSUE) begin
            out_stb_d   = 1'b1;
            out_op_d    = lat_op_q;
            out_instr_d = lat_instr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            lat_op_q    <= '0;
            lat_instr_q <= '0;
            out_stb_q   <= 1'b0;
            out_op_q    <= '0;
            out_instr_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            lat_op_q    <= lat_op_d;
            lat_instr_q <= lat_instr_d;
            out_stb_q   <= out_stb_d;
            out_op_q    <= out_op_d;
            out_instr_q <= out_instr_d;
        end
    end

    assign out_stb   = out_stb_q;
    assign out_op    = out_op_q;
    assign out_instr = out_instr_q;
    assign busy      = (state_q != ST_IDLE) || (level != '0);

endmodule
